seq_keyer: RTL and testbench

Serial code transmitter that drives the single-bit `A` input of the sequence-detecting lock. On a start request it latches a CODE_LEN-bit code and shifts it out MSB first, one bit per clock. It then holds `A` low for a guard gap and signals completion. It sits upstream of the lock, on the same clock, as the initiator side of the one-wire unlock protocol.

---
 rtl/seq_keyer.sv | 151 +++++++++++++++
 tb/tb_seq_keyer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_keyer.sv
// Serial code transmitter: shifts a latched code out MSB first on A, then a guard gap and done pulse.
// Optional unlock monitoring with retries is enabled by defining SEQ_KEYER_UNLOCK_CHECK_EN.
module seq_keyer #(
    parameter int unsigned CODE_LEN   = 4,
    parameter int unsigned GAP_CYCLES = 2,
    parameter int unsigned MAX_TRIES  = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [CODE_LEN-1:0] code,
    output logic                A,
    output logic                busy,
`ifdef SEQ_KEYER_UNLOCK_CHECK_EN
    input  logic                unlock,
    output logic                success,
    output logic                fail,
`endif
    output logic                done
);

    localparam int unsigned BIT_W = $clog2(CODE_LEN) + 1;
    localparam int unsigned GAP_W = $clog2(GAP_CYCLES) + 1;

    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

    state_t              state, state_nx;
    logic [CODE_LEN-1:0] shreg, shreg_nx;
    logic [BIT_W-1:0]    bit_cnt, bit_cnt_nx;
    logic [GAP_W-1:0]    gap_cnt, gap_cnt_nx;
    logic                a_nx, busy_nx, done_nx;

`ifdef SEQ_KEYER_UNLOCK_CHECK_EN
    localparam int unsigned TRY_W = $clog2(MAX_TRIES) + 1;

    logic [TRY_W-1:0]    tries, tries_nx, tries_inc;
    logic [CODE_LEN-1:0] code_lat, code_lat_nx;
    logic                seen, seen_nx;
    logic                success_nx, fail_nx;
`endif

    // State, datapath and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            A       <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef SEQ_KEYER_UNLOCK_CHECK_EN
            tries    <= '0;
            code_lat <= '0;
            seen     <= 1'b0;
            success  <= 1'b0;
            fail     <= 1'b0;
`endif
        end else begin
            state   <= state_nx;
            shreg   <= shreg_nx;
            bit_cnt <= bit_cnt_nx;
            gap_cnt <= gap_cnt_nx;
            A       <= a_nx;
            busy    <= busy_nx;
            done    <= done_nx;
`ifdef SEQ_KEYER_UNLOCK_CHECK_EN
            tries    <= tries_nx;
            code_lat <= code_lat_nx;
            seen     <= seen_nx;
            success  <= success_nx;
            fail     <= fail_nx;
`endif
        end
    end

    // Next-state logic; outputs are decoded from the next state so they register cleanly
    always_comb begin
        state_nx   = state;
        shreg_nx   = shreg;
        bit_cnt_nx = bit_cnt;
        gap_cnt_nx = gap_cnt;
`ifdef SEQ_KEYER_UNLOCK_CHECK_EN
        tries_nx    = tries;
        tries_inc   = tries + TRY_W'(1);
        code_lat_nx = code_lat;
        seen_nx     = seen;
        success_nx  = success;
        fail_nx     = fail;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx   = SEND;
                    shreg_nx   = code;
                    bit_cnt_nx = '0;
                    gap_cnt_nx = '0;
`ifdef SEQ_KEYER_UNLOCK_CHECK_EN
                    tries_nx    = '0;
                    code_lat_nx = code;
                    seen_nx     = 1'b0;
                    success_nx  = 1'b0;
                    fail_nx     = 1'b0;
`endif
                end
            end
            SEND: begin
                shreg_nx   = {shreg[CODE_LEN-2:0], 1'b0};
                bit_cnt_nx = bit_cnt + BIT_W'(1);
                if (bit_cnt == BIT_W'(CODE_LEN - 1)) begin
                    state_nx   = GAP;
                    gap_cnt_nx = '0;
                end
            end
            GAP: begin
                gap_cnt_nx = gap_cnt + GAP_W'(1);
`ifdef SEQ_KEYER_UNLOCK_CHECK_EN
                seen_nx = seen | unlock;
                if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                    // Unlock may arrive on any gap edge; the gap always runs to its end
                    if (seen | unlock) begin
                        success_nx = 1'b1;
                        state_nx   = DONE;
                    end else if (tries_inc < TRY_W'(MAX_TRIES)) begin
                        tries_nx   = tries_inc;
                        shreg_nx   = code_lat;
                        bit_cnt_nx = '0;
                        seen_nx    = 1'b0;
                        state_nx   = SEND;
                    end else begin
                        tries_nx = tries_inc;
                        fail_nx  = 1'b1;
                        state_nx = DONE;
                    end
                end
`else
                if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                    state_nx = DONE;
                end
`endif
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        a_nx    = (state_nx == SEND) & shreg_nx[CODE_LEN-1];
        busy_nx = (state_nx == SEND) || (state_nx == GAP);
        done_nx = (state_nx == DONE);
    end

endmodule

// File: tb/tb_seq_keyer.sv
// Directed self-checking bench for seq_keyer (CODE_LEN=4, GAP_CYCLES=2, MAX_TRIES=3).
// Unlock scenarios run when SEQ_KEYER_UNLOCK_CHECK_EN is defined.
module tb_seq_keyer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] code;
    logic       A, busy, done;
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

`ifdef SEQ_KEYER_UNLOCK_CHECK_EN
    logic       unlock, success, fail;
    logic [3:0] hist;

    // Moore lock accepting 0110: unlock is high the cycle after the last matching bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) hist <= '0;
        else       hist <= {hist[2:0], A};
    end
    assign unlock = (hist == 4'b0110);
`endif

    seq_keyer #(.CODE_LEN(4), .GAP_CYCLES(2), .MAX_TRIES(3)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .code   (code),
        .A      (A),
        .busy   (busy),
`ifdef SEQ_KEYER_UNLOCK_CHECK_EN
        .unlock (unlock),
        .success(success),
        .fail   (fail),
`endif
        .done   (done)
    );

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; code = '0;
        #10 reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            n_cmp++;
            if ({A, busy, done} !== 3'b000) begin
                n_err++;
                $display("FAIL reset_idle k=%0d got A/busy/done=%b want 000", k, {A, busy, done});
            end
`ifdef SEQ_KEYER_UNLOCK_CHECK_EN
            n_cmp++;
            if ({success, fail} !== 2'b00) begin
                n_err++;
                $display("FAIL reset_flags k=%0d got success/fail=%b want 00", k, {success, fail});
            end
`endif
            @(negedge clk);
        end
    endtask

    task automatic test_single_send;
        logic [3:0] c;
        logic ea, eb, ed;
        c = 4'b0110;
        start = 1'b1; code = c;
        @(negedge clk) start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            ea = (k < 4) ? c[3-k] : 1'b0;
            eb = (k < 6);
            ed = (k == 6);
            n_cmp++;
            if ({A, busy, done} !== {ea, eb, ed}) begin
                n_err++;
                $display("FAIL single_send k=%0d got A/busy/done=%b want %b", k, {A, busy, done}, {ea, eb, ed});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] c;
        logic ea, eb, ed;
        c = 4'b1011;
        start = 1'b1; code = c;
        @(negedge clk);
        for (int k = 0; k < 9; k++) begin
            ea = (k < 4) ? c[3-k] : ((k == 8) ? c[3] : 1'b0);
            eb = (k < 6) || (k == 8);
            ed = (k == 6);
            n_cmp++;
            if ({A, busy, done} !== {ea, eb, ed}) begin
                n_err++;
                $display("FAIL back_to_back k=%0d got A/busy/done=%b want %b", k, {A, busy, done}, {ea, eb, ed});
            end
            @(negedge clk);
        end
        start = 1'b0;
        repeat (8) @(negedge clk);
        n_cmp++;
        if ({A, busy, done} !== 3'b000) begin
            n_err++;
            $display("FAIL back_to_back_idle got A/busy/done=%b want 000", {A, busy, done});
        end
    endtask

    task automatic test_busy_start;
        logic [3:0] c;
        logic ea, eb, ed;
        c = 4'b1001;
        start = 1'b1; code = c;
        @(negedge clk) start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            ea = (k < 4) ? c[3-k] : 1'b0;
            eb = (k < 6);
            ed = (k == 6);
            n_cmp++;
            if ({A, busy, done} !== {ea, eb, ed}) begin
                n_err++;
                $display("FAIL busy_start k=%0d got A/busy/done=%b want %b", k, {A, busy, done}, {ea, eb, ed});
            end
            if (k == 1) begin start = 1'b1; code = 4'b0110; end
            if (k == 2) start = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid;
        logic [3:0] c;
        logic ea, eb, ed;
        c = 4'b1110;
        start = 1'b1; code = c;
        @(negedge clk) start = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({A, busy} !== 2'b11) begin
            n_err++;
            $display("FAIL reset_mid_bit2 got A/busy=%b want 11", {A, busy});
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({A, busy, done} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_mid_async got A/busy/done=%b want 000", {A, busy, done});
        end
        @(negedge clk) reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if ({A, busy, done} !== 3'b000) begin
                n_err++;
                $display("FAIL reset_mid_quiet k=%0d got A/busy/done=%b want 000", k, {A, busy, done});
            end
            @(negedge clk);
        end
        start = 1'b1; code = c;
        @(negedge clk) start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            ea = (k < 4) ? c[3-k] : 1'b0;
            eb = (k < 6);
            ed = (k == 6);
            n_cmp++;
            if ({A, busy, done} !== {ea, eb, ed}) begin
                n_err++;
                $display("FAIL reset_mid_resend k=%0d got A/busy/done=%b want %b", k, {A, busy, done}, {ea, eb, ed});
            end
            @(negedge clk);
        end
    endtask

`ifdef SEQ_KEYER_UNLOCK_CHECK_EN
    task automatic test_unlock_success;
        logic [3:0] c;
        logic eb, ed, eu;
        c = 4'b0110;
        start = 1'b1; code = c;
        @(negedge clk) start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            eb = (k < 6);
            ed = (k == 6);
            eu = (k == 4);
            n_cmp++;
            if ({busy, done, unlock} !== {eb, ed, eu}) begin
                n_err++;
                $display("FAIL unlock_success k=%0d got busy/done/unlock=%b want %b", k, {busy, done, unlock}, {eb, ed, eu});
            end
            n_cmp++;
            if ({success, fail} !== {(k >= 6), 1'b0}) begin
                n_err++;
                $display("FAIL unlock_success_flags k=%0d got success/fail=%b want %b", k, {success, fail}, {(k >= 6), 1'b0});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_unlock_fail;
        logic [3:0] c;
        logic ea, eb, ed;
        int   p;
        c = 4'b0101;
        start = 1'b1; code = c;
        @(negedge clk) start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            p  = k % 6;
            ea = (k < 18 && p < 4) ? c[3-p] : 1'b0;
            eb = (k < 18);
            ed = (k == 18);
            n_cmp++;
            if ({A, busy, done} !== {ea, eb, ed}) begin
                n_err++;
                $display("FAIL unlock_fail k=%0d got A/busy/done=%b want %b", k, {A, busy, done}, {ea, eb, ed});
            end
            n_cmp++;
            if ({success, fail} !== {1'b0, (k >= 18)}) begin
                n_err++;
                $display("FAIL unlock_fail_flags k=%0d got success/fail=%b want %b", k, {success, fail}, {1'b0, (k >= 18)});
            end
            @(negedge clk);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_single_send;
        test_back_to_back;
        test_busy_start;
        test_reset_mid;
`ifdef SEQ_KEYER_UNLOCK_CHECK_EN
        test_unlock_success;
        test_unlock_fail;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
